// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ req/gnt ports.
// Locked bursts keep the grant, capped at MAX_HOLD consecutive grants while another port waits.
module axi_mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic                            s_axi_clk,
  input  logic                            s_axi_rst_n,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            ram_cs,
  output logic                            ram_we,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_wstrb,
  output logic [DATA_WIDTH-1:0]           ram_din,
  input  logic [DATA_WIDTH-1:0]           ram_dout
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(MAX_HOLD + 1);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic {ARB, HOLD} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   owner, owner_d;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_found;
  logic               others_req;
  logic               cap_hit;
  logic               hold_grant;
  logic [STRB_W-1:0]  wstrb_sel;

  // Rotating priority: search starts just after the most recently granted port.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign others_req = |(req_i & ~(NUM_REQ'(1) << owner));
  // Cap reached under contention: owner is passed over and arbitration picks the next port.
  assign cap_hit    = (hold_cnt == CNT_W'(MAX_HOLD)) && others_req;
  assign hold_grant = (state == HOLD) && req_i[owner] && !cap_hit;

  always_comb begin
    gnt_c      = '0;
    sel        = '0;
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    hold_cnt_d = hold_cnt;
    if (hold_grant) begin
      gnt_c[owner] = 1'b1;
      sel          = owner;
      if (!lock_i[owner]) begin
        state_d    = ARB;
        hold_cnt_d = '0;
      end else if (others_req) begin
        hold_cnt_d = hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt_d = CNT_W'(1);
      end
    end else begin
      state_d    = ARB;
      hold_cnt_d = '0;
      if (arb_found) begin
        gnt_c[arb_idx] = 1'b1;
        sel            = arb_idx;
        rr_ptr_d       = arb_idx;
        if (lock_i[arb_idx]) begin
          state_d    = HOLD;
          owner_d    = arb_idx;
          hold_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  assign gnt_o = s_axi_rst_n ? gnt_c : '0;

  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) begin
      state    <= ARB;
      rr_ptr   <= PTR_W'(NUM_REQ - 1);
      owner    <= '0;
      hold_cnt <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      owner    <= owner_d;
      hold_cnt <= hold_cnt_d;
      rvalid_q <= gnt_o & ~we_i;
    end
  end

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = ram_dout;
  assign ram_cs    = |gnt_o;
  assign ram_we    = we_i[sel];
  assign ram_addr  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_din   = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign wstrb_sel = wstrb_i[int'(sel)*STRB_W +: STRB_W];

  always_comb begin
    ram_wstrb = '0;
    for (int b = 0; b < STRB_W; b++) begin
      ram_wstrb[8*b +: 8] = {8{wstrb_sel[b]}};
    end
  end

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Bench for axi_mem_port_arbiter: behavioural RAM, read-return scoreboard, one task per scenario.
module tb_axi_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req, we, lock;
  logic [NR*AW-1:0] addr;
  logic [NR*DW/8-1:0] wstrb;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]   gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_cs, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wstrb, ram_din, ram_dout;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  axi_mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
  ) dut (
    .s_axi_clk(clk),
    .s_axi_rst_n(rst_n),
    .req_i(req),
    .we_i(we),
    .lock_i(lock),
    .addr_i(addr),
    .wstrb_i(wstrb),
    .wdata_i(wdata),
    .gnt_o(gnt),
    .rvalid_o(rvalid),
    .rdata_o(rdata),
    .ram_cs(ram_cs),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wstrb(ram_wstrb),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Bit-write single-port RAM, read data one cycle after a read select.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= (mem[ram_addr] & ~ram_wstrb) | (ram_din & ram_wstrb);
      else        ram_dout <= mem[ram_addr];
    end
  end

  // Read-return monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rvalid actual rvalid=%b rdata=%h required none", rvalid, rdata);
      end else begin
        mon_e = sb.pop_front();
        if (rvalid !== (NR'(1) << mon_e.port) || rdata !== mon_e.data) begin
          errors++;
          $display("FAIL sb_read_return actual rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                   rvalid, rdata, NR'(1) << mon_e.port, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    req = '0; we = '0; lock = '0; addr = '0; wstrb = '0; wdata = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic l, input logic [AW-1:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    req[p] = 1'b1;
    we[p] = w;
    lock[p] = l;
    addr[p*AW +: AW] = a;
    wstrb[p*4 +: 4] = s;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic reset_dut();
    clr_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_all();
    req = 4'b1111;
    #2;
    checks++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000 || ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs actual gnt=%b rvalid=%b cs=%b required 0000/0000/0", gnt, rvalid, ram_cs);
    end
    clr_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < NR; p++) set_port(p, 1'b1, 1'b0, AW'(16'h100 + p), 4'b0000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (NR'(1) << (i % NR))) begin
        errors++;
        $display("FAIL rr_cycle%0d actual gnt=%b required %b", i, gnt, NR'(1) << (i % NR));
      end
      tick();
    end
    clr_all();
  endtask

  task automatic test_read();
    reset_dut();
    set_port(2, 1'b1, 1'b0, AW'(16'h10), 4'b1111, 32'hDEADBEEF);
    tick();
    we[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL read_gnt actual gnt=%b required 0100", gnt);
    end
    sb.push_back('{port: 2, data: 32'hDEADBEEF});
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_latency actual rvalid=%b rdata=%h required 0100/deadbeef", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_write_strobe();
    set_port(1, 1'b1, 1'b0, AW'(16'h30), 4'b1111, 32'h11223344);
    tick();
    wstrb[4 +: 4] = 4'b0010;
    wdata[32 +: 32] = 32'hAABBCCDD;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || ram_we !== 1'b1 || ram_wstrb !== 32'h0000FF00 || ram_addr !== AW'(16'h30)) begin
      errors++;
      $display("FAIL wstrb_expand actual gnt=%b we=%b wstrb=%h addr=%h required 0010/1/0000ff00/0030",
               gnt, ram_we, ram_wstrb, ram_addr);
    end
    tick();
    we[1] = 1'b0;
    @(negedge clk);
    sb.push_back('{port: 1, data: 32'h1122CC44});
    tick();
    clr_all();
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_port(3, 1'b1, 1'b0, AW'(16'h40 + i), 4'b1111, 32'hC0DE0000 + i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_port(3, 1'b0, 1'b0, AW'(16'h40 + i), 4'b0000, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt !== 4'b1000) begin
        errors++;
        $display("FAIL b2b_gnt%0d actual gnt=%b required 1000", i, gnt);
      end
      sb.push_back('{port: 3, data: 32'hC0DE0000 + i});
      tick();
    end
    clr_all();
    repeat (2) tick();
  endtask

  task automatic test_hold_cap();
    int n = 0;
    reset_dut();
    set_port(0, 1'b1, 1'b1, AW'(16'h200), 4'b0000, 32'h0);
    set_port(3, 1'b1, 1'b0, AW'(16'h201), 4'b0000, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0001) break;
      n++;
      tick();
    end
    checks++;
    if (n != MH) begin
      errors++;
      $display("FAIL hold_cap_count actual %0d port0 grants required %0d", n, MH);
    end
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL hold_cap_release actual gnt=%b required 1000", gnt);
    end
    tick();
    clr_all();
    tick();
  endtask

  task automatic test_burst_drop();
    reset_dut();
    set_port(0, 1'b1, 1'b1, AW'(16'h300), 4'b0000, 32'h0);
    set_port(1, 1'b1, 1'b0, AW'(16'h301), 4'b0000, 32'h0);
    for (int beat = 1; beat <= 5; beat++) begin
      if (beat == 5) lock[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL burst_beat%0d actual gnt=%b required 0001", beat, gnt);
      end
      tick();
    end
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL burst_handoff actual gnt=%b required 0010", gnt);
    end
    tick();
    clr_all();
  endtask

  task automatic test_reset_in_hold();
    reset_dut();
    set_port(0, 1'b1, 1'b0, AW'(16'h50), 4'b1111, 32'h5A5A1234);
    tick();
    set_port(0, 1'b0, 1'b1, AW'(16'h50), 4'b0000, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_hold_first actual gnt=%b required 0001", gnt);
    end
    sb.push_back('{port: 0, data: 32'h5A5A1234});
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_hold_second actual gnt=%b required 0001", gnt);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_burst actual gnt=%b rvalid=%b required 0000/0000", gnt, rvalid);
    end
    clr_all();
    set_port(0, 1'b1, 1'b0, AW'(16'h60), 4'b0000, 32'h0);
    set_port(2, 1'b1, 1'b0, AW'(16'h61), 4'b0000, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_post_prio actual gnt=%b required 0001", gnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rst_post_next actual gnt=%b required 0100", gnt);
    end
    tick();
    clr_all();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr_all();
    test_reset();
    test_round_robin();
    test_read();
    test_write_strobe();
    test_back_to_back();
    test_hold_cap();
    test_burst_drop();
    test_reset_in_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual %0d pending reads required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
